// File: rtl/caxi4interconnect_cdc_pkg.sv
// Shared gray-pointer CDC FIFO helpers: pointer code conversions and default sizing
// used by both the read-side and write-side controllers.
package caxi4interconnect_cdc_pkg;

   localparam int CDC_ADDR_WIDTH  = 3;
   localparam int CDC_SYNC_STAGES = 2;

   // Width-parameterised conversions; call as gray_conv#(W)::bin2gray(x).
   virtual class gray_conv #(parameter int W = CDC_ADDR_WIDTH);
      static function logic [W-1:0] bin2gray(input logic [W-1:0] b);
         return b ^ (b >> 1);
      endfunction

      static function logic [W-1:0] gray2bin(input logic [W-1:0] g);
         logic [W-1:0] b;
         b[W-1] = g[W-1];
         for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
         return b;
      endfunction
   endclass

endpackage

// File: rtl/cdc_ptr_sync.sv
// Multi-flop synchroniser for a gray-coded FIFO pointer crossing into this clock
// domain; shared by both sides of the CDC FIFO.
module cdc_ptr_sync
   import caxi4interconnect_cdc_pkg::*;
#(
   parameter int WIDTH  = CDC_ADDR_WIDTH,
   parameter int STAGES = CDC_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sync_p [STAGES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) sync_p[i] <= '0;
      end else begin
         sync_p[0] <= din;
         for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
      end
   end

   assign dout = sync_p[STAGES-1];

endmodule

// File: rtl/cdc_rd_ctrl.sv
// Read-side controller of the gray-pointer CDC FIFO: syncs the write pointer, detects
// empty, advances the read pointer and feeds a registered valid/ready output stage.
// Optional synchronised occupancy output enabled by defining CAXI4_CDC_RD_LEVEL_EN.
module cdc_rd_ctrl
   import caxi4interconnect_cdc_pkg::*;
#(
   parameter int ADDR_WIDTH  = CDC_ADDR_WIDTH,
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = CDC_SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] wrPtr_gray,
   output logic [ADDR_WIDTH-1:0] rdPtr_gray,
   output logic [ADDR_WIDTH-1:0] rdAddr,
   output logic                  fifoRe,
   input  logic [DATA_WIDTH-1:0] ramData,
   output logic [DATA_WIDTH-1:0] infoOut,
   output logic                  infoOutValid,
   input  logic                  infoOutReady,
   output logic [ADDR_WIDTH-1:0] rdLevel
);

   logic [ADDR_WIDTH-1:0] wrPtrSync;
   logic [ADDR_WIDTH-1:0] rdBin;
   logic [ADDR_WIDTH-1:0] rdBinNext;
   logic                  empty;

   cdc_ptr_sync #(
      .WIDTH (ADDR_WIDTH),
      .STAGES(SYNC_STAGES)
   ) u_wr_sync (
      .clk (clk),
      .rst (rst),
      .din (wrPtr_gray),
      .dout(wrPtrSync)
   );

   // Empty is judged against the synchronised pointer, so it is pessimistic by design.
   assign empty     = (wrPtrSync == rdPtr_gray);
   assign fifoRe    = !empty && (!infoOutValid || infoOutReady);
   assign rdBinNext = rdBin + 1'b1;
   assign rdAddr    = rdBin;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdBin        <= '0;
         rdPtr_gray   <= '0;
         infoOut      <= '0;
         infoOutValid <= 1'b0;
      end else if (fifoRe) begin
         rdBin        <= rdBinNext;
         rdPtr_gray   <= gray_conv#(ADDR_WIDTH)::bin2gray(rdBinNext);
         infoOut      <= ramData;
         infoOutValid <= 1'b1;
      end else if (infoOutReady) begin
         infoOutValid <= 1'b0;
      end
   end

`ifdef CAXI4_CDC_RD_LEVEL_EN
   // Counts entries still in the RAM, excluding the one parked in the output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rdLevel <= '0;
      else      rdLevel <= gray_conv#(ADDR_WIDTH)::gray2bin(wrPtrSync) - rdBin;
   end
`else
   assign rdLevel = '0;
`endif

endmodule

// File: tb/tb_cdc_rd_ctrl.sv
// Scoreboard bench for cdc_rd_ctrl: a behavioural write side feeds the FIFO RAM and an
// independent monitor checks pointers, read strobes and delivered data every cycle.
module tb_cdc_rd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] wrPtr_gray = '0;
   logic [2:0] rdPtr_gray;
   logic [2:0] rdAddr;
   logic       fifoRe;
   logic [7:0] ramData;
   logic [7:0] infoOut;
   logic       infoOutValid;
   logic       infoOutReady = 1'b1;
   logic [2:0] rdLevel;

   logic [7:0] mem [8];
   logic [7:0] exp_q [$];
   int checks = 0, failures = 0;
   int wcnt = 0, delivered = 0, rdcnt = 0, re_pulses = 0, cur_run = 0, max_run = 0;
   int w_d1 = 0, w_d2 = 0;
   logic       hold_pend = 1'b0;
   logic [7:0] held = '0;

   always #5 clk = ~clk;

   assign ramData = mem[rdAddr];

   cdc_rd_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .wrPtr_gray  (wrPtr_gray),
      .rdPtr_gray  (rdPtr_gray),
      .rdAddr      (rdAddr),
      .fifoRe      (fifoRe),
      .ramData     (ramData),
      .infoOut     (infoOut),
      .infoOutValid(infoOutValid),
      .infoOutReady(infoOutReady),
      .rdLevel     (rdLevel)
   );

   function automatic logic [2:0] gray(input int n);
      logic [2:0] b;
      b = 3'(n);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic ok, input int act, input int req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Two-flop synchroniser model: the read side sees the write count two edges late.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_d1 <= 0;
         w_d2 <= 0;
      end else begin
         w_d1 <= wcnt;
         w_d2 <= w_d1;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rdPtr_gray", rdPtr_gray == gray(rdcnt), int'(rdPtr_gray), int'(gray(rdcnt)));
         chk("rdAddr", rdAddr == 3'(rdcnt), int'(rdAddr), rdcnt % 8);
         chk("fifoRe", fifoRe == ((w_d2 > rdcnt) && (!infoOutValid || infoOutReady)),
             int'(fifoRe), int'((w_d2 > rdcnt) && (!infoOutValid || infoOutReady)));
`ifndef CAXI4_CDC_RD_LEVEL_EN
         chk("rdLevel_zero", rdLevel == 3'd0, int'(rdLevel), 0);
`endif
         if (hold_pend && infoOutValid)
            chk("hold_data", infoOut == held, int'(infoOut), int'(held));
         hold_pend = infoOutValid && !infoOutReady;
         held      = infoOut;
         if (infoOutValid && infoOutReady) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1'b0, int'(infoOut), -1);
            end else begin
               chk("data_order", infoOut == exp_q[0], int'(infoOut), int'(exp_q[0]));
               void'(exp_q.pop_front());
            end
            delivered++;
         end
         if (fifoRe) begin
            rdcnt++;
            re_pulses++;
            cur_run++;
            if (cur_run > max_run) max_run = cur_run;
         end else begin
            cur_run = 0;
         end
      end
   end

   task automatic push(input logic [7:0] d);
      int n = 0;
      while ((wcnt - delivered) >= 7 && n < 200) begin
         cyc();
         n++;
      end
      chk("push_space_wait", n < 200, n, 200);
      mem[wcnt % 8] = d;
      wcnt++;
      wrPtr_gray = gray(wcnt);
      exp_q.push_back(d);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdPtr_gray"}, rdPtr_gray == 3'd0, int'(rdPtr_gray), 0);
      chk({tag, "_rdAddr"}, rdAddr == 3'd0, int'(rdAddr), 0);
      chk({tag, "_infoOut"}, infoOut == 8'd0, int'(infoOut), 0);
      chk({tag, "_infoOutValid"}, infoOutValid == 1'b0, int'(infoOutValid), 0);
      chk({tag, "_rdLevel"}, rdLevel == 3'd0, int'(rdLevel), 0);
      chk({tag, "_fifoRe"}, fifoRe == 1'b0, int'(fifoRe), 0);
   endtask

   // Both FIFO domains reset together: write side model clears alongside the DUT.
   task automatic clear_model();
      wcnt = 0; delivered = 0; rdcnt = 0; cur_run = 0;
      wrPtr_gray = '0;
      hold_pend = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      int base, d0;
      for (int i = 0; i < 8; i++) mem[i] = '0;

      // Power-on reset
      #2;
      check_reset_outputs("por");
      cyc(); cyc();
      rst = 1'b1;
      cyc();

      // Single entry latency
      push(8'hA5);
      cyc();
      chk("single_re_edge1", fifoRe == 1'b0, int'(fifoRe), 0);
      cyc();
      chk("single_re_edge2", fifoRe == 1'b1, int'(fifoRe), 1);
      cyc();
      chk("single_valid", infoOutValid == 1'b1, int'(infoOutValid), 1);
      chk("single_data", infoOut == 8'hA5, int'(infoOut), 8'hA5);
      chk("single_gray", rdPtr_gray == 3'b001, int'(rdPtr_gray), 1);
      chk("single_re_after", fifoRe == 1'b0, int'(fifoRe), 0);
      cyc();

      // Backpressure
      infoOutReady = 1'b0;
      base = re_pulses;
      push(8'h31); cyc();
      push(8'h32); cyc();
      push(8'h33);
      repeat (6) cyc();
      chk("bp_one_read", re_pulses - base == 1, re_pulses - base, 1);
      chk("bp_held_data", infoOut == 8'h31, int'(infoOut), 8'h31);
      base = delivered;
      infoOutReady = 1'b1;
      repeat (3) cyc();
      chk("bp_three_out", delivered - base == 3, delivered - base, 3);
      cyc();

      // Reset mid-stream with entries pending
      infoOutReady = 1'b0;
      push(8'h41); cyc();
      push(8'h42); cyc();
      push(8'h43);
      repeat (4) cyc();
      #1;
      rst = 1'b0;
      clear_model();
      #1;
      check_reset_outputs("mid");
      cyc(); cyc();
      rst = 1'b1;
      infoOutReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("post_reset_idle", fifoRe == 1'b0, int'(fifoRe), 0);
      end

      // Streaming with pointer wrap
      base = re_pulses;
      max_run = 0;
      for (int i = 0; i < 7; i++) begin
         push(8'(8'h10 + i));
         cyc();
      end
      repeat (6) cyc();
      chk("stream_reads", re_pulses - base == 7, re_pulses - base, 7);
      chk("stream_consecutive", max_run == 7, max_run, 7);
      chk("stream_gray_end", rdPtr_gray == 3'b100, int'(rdPtr_gray), 4);
      chk("stream_addr_end", rdAddr == 3'd7, int'(rdAddr), 7);
      for (int i = 0; i < 3; i++) begin
         push(8'(8'h17 + i));
         cyc();
      end
      repeat (6) cyc();
      chk("refill_addr", rdAddr == 3'd2, int'(rdAddr), 2);

      // Ready toggling
      base = delivered;
      for (int i = 0; i < 24; i++) begin
         infoOutReady = (i % 2 == 0);
         if (i < 5) push(8'(8'h50 + i));
         cyc();
      end
      infoOutReady = 1'b1;
      cyc(); cyc();
      chk("toggle_delivered", delivered - base == 5, delivered - base, 5);

      // Level
      infoOutReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push(8'(8'h60 + i));
         cyc();
      end
      repeat (8) cyc();
`ifdef CAXI4_CDC_RD_LEVEL_EN
      chk("level_four", rdLevel == 3'd4, int'(rdLevel), 4);
`else
      chk("level_off", rdLevel == 3'd0, int'(rdLevel), 0);
`endif
      infoOutReady = 1'b1;
      repeat (10) cyc();

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         infoOutReady = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1 && (wcnt - delivered) < 7)
            push(8'($urandom));
         cyc();
      end
      infoOutReady = 1'b1;
      d0 = 0;
      while (exp_q.size() != 0 && d0 < 100) begin
         cyc();
         d0++;
      end
      chk("drain_empty", exp_q.size() == 0, exp_q.size(), 0);
      chk("drain_count", delivered == wcnt, delivered, wcnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
